// File: rtl/vdp_cpu_port.sv
// CPU I/O port front end of the VDP: decodes the four ports into VRAM
// accesses, control-register writes, status reads and palette writes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | bus_ready high, no VRAM request outstanding
// VWRITE | VRAM write presented, holding it until vram_ready
// VREAD  | VRAM prefetch presented, then waiting for vram_rdata_en
module vdp_cpu_port (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  bus_address,
  input  logic        bus_ioreq,
  input  logic        bus_write,
  input  logic        bus_valid,
  input  logic [7:0]  bus_wdata,
  output logic        bus_ready,
  output logic [7:0]  bus_rdata,
  output logic        bus_rdata_en,
  output logic [16:0] vram_address,
  output logic        vram_write,
  output logic        vram_valid,
  output logic [7:0]  vram_wdata,
  input  logic        vram_ready,
  input  logic [7:0]  vram_rdata,
  input  logic        vram_rdata_en,
  output logic        reg_write,
  output logic [5:0]  reg_num,
  output logic [7:0]  reg_data,
  input  logic [7:0]  status_data,
  output logic        status_read,
  output logic        palette_write,
  output logic [3:0]  palette_num,
  output logic [8:0]  palette_rgb
);

  typedef enum logic [1:0] {IDLE, VWRITE, VREAD} state_t;

  state_t      state;
  logic        ff;
  logic [7:0]  latch;
  logic        pal_ff;
  logic [7:0]  pal_latch;
  logic [7:0]  buffer;
  logic [2:0]  r14;
  logic [3:0]  r16;
  logic [7:0]  r17;

  logic        accept;
  logic        sh_we;
  logic [5:0]  sh_num;
  logic [7:0]  sh_data;

  // Both register-write paths (port 1 second byte, port 3 indirect) merge here
  always_comb begin
    accept  = bus_valid & bus_ioreq & bus_ready;
    sh_we   = 1'b0;
    sh_num  = 6'd0;
    sh_data = 8'd0;
    if (accept && bus_write && bus_address == 2'd1 && ff && bus_wdata[7]) begin
      sh_we   = 1'b1;
      sh_num  = bus_wdata[5:0];
      sh_data = latch;
    end else if (accept && bus_write && bus_address == 2'd3 && r17[5:0] != 6'd17) begin
      sh_we   = 1'b1;
      sh_num  = r17[5:0];
      sh_data = bus_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus_ready     <= 1'b0;
      bus_rdata     <= 8'd0;
      bus_rdata_en  <= 1'b0;
      vram_address  <= 17'd0;
      vram_write    <= 1'b0;
      vram_valid    <= 1'b0;
      vram_wdata    <= 8'd0;
      reg_write     <= 1'b0;
      reg_num       <= 6'd0;
      reg_data      <= 8'd0;
      status_read   <= 1'b0;
      palette_write <= 1'b0;
      palette_num   <= 4'd0;
      palette_rgb   <= 9'd0;
      ff            <= 1'b0;
      latch         <= 8'd0;
      pal_ff        <= 1'b0;
      pal_latch     <= 8'd0;
      buffer        <= 8'd0;
      r14           <= 3'd0;
      r16           <= 4'd0;
      r17           <= 8'd0;
    end else begin
      bus_rdata_en  <= 1'b0;
      reg_write     <= 1'b0;
      status_read   <= 1'b0;
      palette_write <= 1'b0;

      if (sh_we) begin
        reg_write <= 1'b1;
        reg_num   <= sh_num;
        reg_data  <= sh_data;
        case (sh_num)
          6'd14:   r14 <= sh_data[2:0];
          6'd16:   r16 <= sh_data[3:0];
          6'd17:   r17 <= sh_data;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          bus_ready <= 1'b1;
          if (accept && bus_write) begin
            case (bus_address)
              2'd0: begin
                ff         <= 1'b0;
                vram_write <= 1'b1;
                vram_valid <= 1'b1;
                vram_wdata <= bus_wdata;
                bus_ready  <= 1'b0;
                state      <= VWRITE;
              end
              2'd1: begin
                if (!ff) begin
                  latch <= bus_wdata;
                  ff    <= 1'b1;
                end else begin
                  ff <= 1'b0;
                  if (!bus_wdata[7]) begin
                    vram_address <= {r14, bus_wdata[5:0], latch};
                    if (!bus_wdata[6]) begin
                      vram_write <= 1'b0;
                      vram_valid <= 1'b1;
                      bus_ready  <= 1'b0;
                      state      <= VREAD;
                    end
                  end
                end
              end
              2'd2: begin
                if (!pal_ff) begin
                  pal_latch <= bus_wdata;
                  pal_ff    <= 1'b1;
                end else begin
                  pal_ff        <= 1'b0;
                  palette_write <= 1'b1;
                  palette_num   <= r16;
                  palette_rgb   <= {pal_latch[6:4], pal_latch[2:0], bus_wdata[2:0]};
                  r16           <= r16 + 4'd1;
                end
              end
              2'd3: begin
                if (!r17[7]) r17[5:0] <= r17[5:0] + 6'd1;
              end
            endcase
          end else if (accept) begin
            bus_rdata_en <= 1'b1;
            case (bus_address)
              2'd0: begin
                // Hand out the prefetched byte and fetch the next one
                ff           <= 1'b0;
                bus_rdata    <= buffer;
                vram_address <= vram_address + 17'd1;
                vram_write   <= 1'b0;
                vram_valid   <= 1'b1;
                bus_ready    <= 1'b0;
                state        <= VREAD;
              end
              2'd1: begin
                ff          <= 1'b0;
                bus_rdata   <= status_data;
                status_read <= 1'b1;
              end
              default: bus_rdata <= 8'd0;
            endcase
          end
        end
        VWRITE: begin
          if (vram_ready) begin
            vram_valid   <= 1'b0;
            vram_write   <= 1'b0;
            vram_address <= vram_address + 17'd1;
            bus_ready    <= 1'b1;
            state        <= IDLE;
          end
        end
        VREAD: begin
          if (vram_valid && vram_ready) vram_valid <= 1'b0;
          if ((!vram_valid || vram_ready) && vram_rdata_en) begin
            buffer     <= vram_rdata;
            vram_valid <= 1'b0;
            bus_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a small VRAM responder and
// monitors for register, palette and status strobes.
module tb_vdp_cpu_port;

  logic        clk;
  logic        reset;
  logic [1:0]  bus_address;
  logic        bus_ioreq;
  logic        bus_write;
  logic        bus_valid;
  logic [7:0]  bus_wdata;
  logic        bus_ready;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_en;
  logic [16:0] vram_address;
  logic        vram_write;
  logic        vram_valid;
  logic [7:0]  vram_wdata;
  logic        vram_ready;
  logic [7:0]  vram_rdata;
  logic        vram_rdata_en;
  logic        reg_write;
  logic [5:0]  reg_num;
  logic [7:0]  reg_data;
  logic [7:0]  status_data;
  logic        status_read;
  logic        palette_write;
  logic [3:0]  palette_num;
  logic [8:0]  palette_rgb;

  vdp_cpu_port dut (
    .clk(clk), .reset(reset),
    .bus_address(bus_address), .bus_ioreq(bus_ioreq), .bus_write(bus_write),
    .bus_valid(bus_valid), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en),
    .vram_address(vram_address), .vram_write(vram_write), .vram_valid(vram_valid),
    .vram_wdata(vram_wdata), .vram_ready(vram_ready), .vram_rdata(vram_rdata),
    .vram_rdata_en(vram_rdata_en),
    .reg_write(reg_write), .reg_num(reg_num), .reg_data(reg_data),
    .status_data(status_data), .status_read(status_read),
    .palette_write(palette_write), .palette_num(palette_num), .palette_rgb(palette_rgb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // VRAM responder: ready on the second cycle of a request, read data one cycle later
  logic [7:0]  mem [logic [16:0]];
  logic [16:0] wlog_a [$];
  logic [7:0]  wlog_d [$];
  bit          resp_en = 1'b1;
  int          late_req = 0;
  int          late_ack = 0;
  int          wcnt = 0;
  bit          pend_rd = 1'b0;
  logic [7:0]  rd_val = 8'h00;

  initial begin
    vram_ready = 1'b0;
    vram_rdata = 8'h00;
    vram_rdata_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vram_ready = 1'b0;
      vram_rdata_en = 1'b0;
      if (late_req != late_ack) begin
        late_ack = late_req;
        vram_rdata_en = 1'b1;
        vram_rdata = 8'hEE;
      end else if (pend_rd) begin
        vram_rdata_en = 1'b1;
        vram_rdata = rd_val;
        pend_rd = 1'b0;
      end else if (resp_en && vram_valid) begin
        if (wcnt == 1) begin
          vram_ready = 1'b1;
          wcnt = 0;
          if (vram_write) begin
            mem[vram_address] = vram_wdata;
            wlog_a.push_back(vram_address);
            wlog_d.push_back(vram_wdata);
          end else begin
            rd_val = mem.exists(vram_address) ? mem[vram_address] : 8'h00;
            pend_rd = 1'b1;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  int         reg_cnt = 0;
  logic [5:0] last_reg_num = '0;
  logic [7:0] last_reg_data = '0;
  int         pal_cnt = 0;
  logic [3:0] last_pal_num = '0;
  logic [8:0] last_pal_rgb = '0;
  int         stat_cnt = 0;
  int         rden_cnt = 0;
  int         overlap = 0;

  always @(negedge clk) begin
    if (reg_write) begin
      reg_cnt++;
      last_reg_num = reg_num;
      last_reg_data = reg_data;
    end
    if (palette_write) begin
      pal_cnt++;
      last_pal_num = palette_num;
      last_pal_rgb = palette_rgb;
    end
    if (status_read) stat_cnt++;
    if (bus_rdata_en) rden_cnt++;
    if (bus_ready && vram_valid) overlap++;
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus_ready !== 1'b1 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bus_ready_wait", {31'b0, bus_ready}, 32'd1);
  endtask

  task automatic xfer(input logic [1:0] a, input logic w, input logic [7:0] d,
                      output logic [7:0] rd);
    wait_ready();
    bus_address = a;
    bus_write = w;
    bus_wdata = d;
    bus_valid = 1'b1;
    bus_ioreq = 1'b1;
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
    bus_ioreq = 1'b0;
    rd = bus_rdata;
    chk(w ? "rden_on_write" : "rden_on_read", {31'b0, bus_rdata_en}, {31'b0, ~w});
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    xfer(a, 1'b1, d, dummy);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    xfer(a, 1'b0, 8'h00, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  logic [7:0] rv;
  int base;

  initial begin
    reset = 1'b1;
    bus_address = 2'd0;
    bus_ioreq = 1'b0;
    bus_write = 1'b0;
    bus_valid = 1'b0;
    bus_wdata = 8'h00;
    status_data = 8'h00;
    mem[17'h00100] = 8'h5A;
    mem[17'h00101] = 8'hA5;
    ticks(3);
    chk("rst_bus_ready", {31'b0, bus_ready}, 32'd0);
    chk("rst_vram_valid", {31'b0, vram_valid}, 32'd0);
    chk("rst_bus_rdata", {24'b0, bus_rdata}, 32'd0);
    chk("rst_vram_address", {15'b0, vram_address}, 32'd0);
    chk("rst_palette_rgb", {23'b0, palette_rgb}, 32'd0);
    reset = 1'b0;
    ticks(1);
    chk("ready_after_reset", {31'b0, bus_ready}, 32'd1);

    // valid without ioreq must not reach port 3 (r17=0 would write reg 0)
    bus_address = 2'd3; bus_write = 1'b1; bus_wdata = 8'h55; bus_valid = 1'b1;
    ticks(2);
    bus_valid = 1'b0;
    ticks(2);
    chk("no_ioreq_ignored", reg_cnt, 0);

    wr(2'd1, 8'h06); wr(2'd1, 8'h82);
    ticks(3);
    chk("reg2_count", reg_cnt, 1);
    chk("reg2_num", {26'b0, last_reg_num}, 32'd2);
    chk("reg2_data", {24'b0, last_reg_data}, 32'h06);

    // r14=1 puts the page bits at 04000h: {001, 12h, 34h} = 05234h
    wr(2'd1, 8'h01); wr(2'd1, 8'h8E);
    wr(2'd1, 8'h34); wr(2'd1, 8'h52);
    wr(2'd0, 8'hAA);
    chk("vw_ready_low", {31'b0, bus_ready}, 32'd0);
    chk("vw_valid", {31'b0, vram_valid}, 32'd1);
    chk("vw_write", {31'b0, vram_write}, 32'd1);
    chk("vw_addr", {15'b0, vram_address}, 32'h05234);
    chk("vw_wdata", {24'b0, vram_wdata}, 32'hAA);
    wr(2'd0, 8'hBB);
    wait_ready();
    chk("vw_log_size", wlog_a.size(), 2);
    chk("vw0_addr", {15'b0, wlog_a[0]}, 32'h05234);
    chk("vw0_data", {24'b0, wlog_d[0]}, 32'hAA);
    chk("vw1_addr", {15'b0, wlog_a[1]}, 32'h05235);
    chk("vw1_data", {24'b0, wlog_d[1]}, 32'hBB);
    chk("vw_addr_after", {15'b0, vram_address}, 32'h05236);

    wr(2'd1, 8'h00); wr(2'd1, 8'h8E);
    wr(2'd1, 8'h00); wr(2'd1, 8'h01);
    chk("prefetch_valid", {31'b0, vram_valid}, 32'd1);
    rd(2'd0, rv);
    chk("vr_first", {24'b0, rv}, 32'h5A);
    rd(2'd0, rv);
    chk("vr_second", {24'b0, rv}, 32'hA5);
    wait_ready();
    chk("vr_addr_after", {15'b0, vram_address}, 32'h00102);

    wr(2'd1, 8'h07); wr(2'd1, 8'h8E);
    wr(2'd1, 8'hFF); wr(2'd1, 8'h7F);
    chk("wrap_addr_setup", {15'b0, vram_address}, 32'h1FFFF);
    wr(2'd0, 8'h3C);
    wait_ready();
    chk("wrap_addr", {15'b0, vram_address}, 32'h00000);
    chk("wrap_log_addr", {15'b0, wlog_a[2]}, 32'h1FFFF);
    chk("wrap_log_data", {24'b0, wlog_d[2]}, 32'h3C);

    status_data = 8'h9F;
    wr(2'd1, 8'h12);
    rd(2'd1, rv);
    chk("status_rdata", {24'b0, rv}, 32'h9F);
    chk("status_pulse", {31'b0, status_read}, 32'd1);
    ticks(2);
    chk("status_count", stat_cnt, 1);
    base = reg_cnt;
    wr(2'd1, 8'h07); wr(2'd1, 8'h87);
    ticks(2);
    chk("ff_cleared_count", reg_cnt, base + 1);
    chk("reg7_num", {26'b0, last_reg_num}, 32'd7);
    chk("reg7_data", {24'b0, last_reg_data}, 32'h07);

    wr(2'd1, 8'h0F); wr(2'd1, 8'h90);
    wr(2'd2, 8'h77); wr(2'd2, 8'h07);
    ticks(2);
    chk("pal_count", pal_cnt, 1);
    chk("pal_num15", {28'b0, last_pal_num}, 32'd15);
    chk("pal_rgb1ff", {23'b0, last_pal_rgb}, 32'h1FF);
    wr(2'd2, 8'h00); wr(2'd2, 8'h05);
    ticks(2);
    chk("pal_num_wrap", {28'b0, last_pal_num}, 32'd0);
    chk("pal_rgb005", {23'b0, last_pal_rgb}, 32'h005);

    wr(2'd1, 8'h05); wr(2'd1, 8'h91);
    wr(2'd3, 8'hAB);
    ticks(2);
    chk("p3_num5", {26'b0, last_reg_num}, 32'd5);
    chk("p3_data_ab", {24'b0, last_reg_data}, 32'hAB);
    wr(2'd3, 8'hCD);
    ticks(2);
    chk("p3_num6", {26'b0, last_reg_num}, 32'd6);
    chk("p3_data_cd", {24'b0, last_reg_data}, 32'hCD);
    // r17=90h: no auto-increment, target reg 16 (palette pointer)
    wr(2'd1, 8'h90); wr(2'd1, 8'h91);
    wr(2'd3, 8'h03); wr(2'd3, 8'h03);
    ticks(2);
    chk("p3_noinc_num", {26'b0, last_reg_num}, 32'd16);
    wr(2'd2, 8'h00); wr(2'd2, 8'h01);
    ticks(2);
    chk("p3_r16_shadow", {28'b0, last_pal_num}, 32'd3);
    chk("p3_r16_rgb", {23'b0, last_pal_rgb}, 32'h001);
    wr(2'd1, 8'h11); wr(2'd1, 8'h91);
    ticks(2);
    base = reg_cnt;
    wr(2'd3, 8'h22);
    ticks(2);
    chk("p3_reg17_skipped", reg_cnt, base);
    wr(2'd3, 8'h44);
    ticks(2);
    chk("p3_after17_count", reg_cnt, base + 1);
    chk("p3_after17_num", {26'b0, last_reg_num}, 32'd18);
    chk("p3_after17_data", {24'b0, last_reg_data}, 32'h44);

    rd(2'd2, rv);
    chk("p2_read_zero", {24'b0, rv}, 32'h00);
    rd(2'd3, rv);
    chk("p3_read_zero", {24'b0, rv}, 32'h00);

    // Reset while a prefetch is outstanding and never answered
    resp_en = 1'b0;
    wr(2'd1, 8'h00); wr(2'd1, 8'h00);
    chk("vread_pending", {31'b0, vram_valid}, 32'd1);
    ticks(2);
    base = rden_cnt;
    reset = 1'b1;
    ticks(1);
    chk("rst_vram_valid_mid", {31'b0, vram_valid}, 32'd0);
    chk("rst_bus_ready_mid", {31'b0, bus_ready}, 32'd0);
    reset = 1'b0;
    late_req++;
    ticks(1);
    chk("ready_after_rst_mid", {31'b0, bus_ready}, 32'd1);
    ticks(3);
    chk("late_rden_no_strobe", rden_cnt, base);
    chk("late_rden_idle_valid", {31'b0, vram_valid}, 32'd0);
    resp_en = 1'b1;
    ticks(1);
    rd(2'd0, rv);
    chk("late_rden_buffer", {24'b0, rv}, 32'h00);
    wait_ready();
    chk("no_ready_during_vram", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
